decode_bundle_queue: RTL and testbench

- WIDTH-lane successor of the single-instruction decode stage.
- Accepts an aligned fetch bundle of up to WIDTH 32-bit RV instructions with a per-lane valid mask, and decodes every lane in parallel.
- Applies per-lane illegal/kill rules and buffers decoded bundles in a DEPTH-entry FIFO ahead of rename.
- Sits between fetch and rename; flushable on redirect.

---
 rtl/decode_pkg.sv | 44 ++++
 rtl/decode_lane.sv | 48 ++++
 rtl/decode_bundle_queue.sv | 86 ++++++++
 tb/tb_decode_bundle_queue.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared decode types, opcode constants and immediate extractors
package decode_pkg;
  localparam int XLEN = 32;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;
  typedef enum logic [2:0] {UOP_ALU, UOP_LOAD, UOP_STORE, UOP_BRANCH, UOP_JUMP, UOP_CSR} uop_e;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [5:0]      rd;
    logic [5:0]      rs1;
    logic [5:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    uop_e            uop;
    logic [11:0]     csr_addr;
    logic            csr_imm_valid;
    logic            rd_we;
    logic            illegal;
  } decoded_t;
  function automatic logic [XLEN-1:0] imm_i_type(logic [31:0] i);
    return XLEN'($signed(i[31:20]));
  endfunction
  function automatic logic [XLEN-1:0] imm_s_type(logic [31:0] i);
    return XLEN'($signed({i[31:25], i[11:7]}));
  endfunction
  function automatic logic [XLEN-1:0] imm_b_type(logic [31:0] i);
    return XLEN'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
  endfunction
  function automatic logic [XLEN-1:0] imm_u_type(logic [31:0] i);
    return XLEN'($signed({i[31:12], 12'b0}));
  endfunction
  function automatic logic [XLEN-1:0] imm_j_type(logic [31:0] i);
    return XLEN'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
  endfunction
endpackage

// File: rtl/decode_lane.sv
// decode_lane: combinational single-lane RV instruction decoder
module decode_lane
  import decode_pkg::*;
(
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output decoded_t        dec
);
  logic [6:0] opc;
  logic [2:0] f3;
  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  always_comb begin
    dec        = '0;
    dec.pc     = pc;
    dec.rd     = {1'b0, instr[11:7]};
    dec.rs1    = {1'b0, instr[19:15]};
    dec.rs2    = {1'b0, instr[24:20]};
    dec.funct3 = f3;
    dec.funct7 = instr[31:25];
    dec.uop    = UOP_ALU;
    case (opc)
      OPC_OP:            dec.illegal = !(instr[31:25] inside {7'h00, 7'h20});
      OPC_OP_IMM:        dec.imm = imm_i_type(instr);
      OPC_LUI, OPC_AUIPC: dec.imm = imm_u_type(instr);
      OPC_LOAD:   begin dec.uop = UOP_LOAD;   dec.imm = imm_i_type(instr); end
      OPC_STORE:  begin dec.uop = UOP_STORE;  dec.imm = imm_s_type(instr); end
      OPC_BRANCH: begin dec.uop = UOP_BRANCH; dec.imm = imm_b_type(instr); end
      OPC_JAL:    begin dec.uop = UOP_JUMP;   dec.imm = imm_j_type(instr); end
      OPC_JALR: begin
        dec.uop     = UOP_JUMP;
        dec.imm     = imm_i_type(instr);
        dec.illegal = f3 != 3'b000;
      end
      OPC_SYSTEM: begin
        dec.uop           = UOP_CSR;
        dec.csr_addr      = instr[31:20];
        dec.illegal       = f3 == 3'b100;
        dec.csr_imm_valid = f3[2];
        dec.imm           = f3[2] ? XLEN'(instr[19:15]) : '0;
        dec.rs1           = f3[2] ? '0 : dec.rs1;
      end
      // every known opcode ends in 2'b11, so compressed encodings land here too
      default: dec.illegal = 1'b1;
    endcase
    dec.rd_we = !dec.illegal && |dec.rd && !(opc inside {OPC_STORE, OPC_BRANCH});
  end
endmodule

// File: rtl/decode_bundle_queue.sv
// decode_bundle_queue: WIDTH-lane parallel decode with kill rules feeding a DEPTH-entry bundle FIFO
module decode_bundle_queue
  import decode_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [WIDTH-1:0]             lane_mask_i,
  input  logic [WIDTH*32-1:0]          instr_i,
  input  logic [XLEN-1:0]              pc_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [WIDTH-1:0]             lane_valid_o,
  output decoded_t [WIDTH-1:0]         dec_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  if (XLEN != decode_pkg::XLEN) begin : g_xlen_chk
    $error("XLEN must equal decode_pkg::XLEN");
  end
  if (WIDTH < 1 || WIDTH > 4 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_size_chk
    $error("WIDTH must be 1..4 and DEPTH a power of two >= 2");
  end
  decoded_t [WIDTH-1:0] lane_dec;
  decoded_t [WIDTH-1:0] wr_dec;
  logic [WIDTH-1:0]     eff_mask;
  logic                 seen;
  decoded_t [WIDTH-1:0] mem_dec  [DEPTH];
  logic [WIDTH-1:0]     mem_mask [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 push, pop;
  for (genvar k = 0; k < WIDTH; k++) begin : g_lane
    decode_lane u_lane (
      .instr(instr_i[32*k +: 32]),
      .pc   (pc_i + XLEN'(4*k)),
      .dec  (lane_dec[k])
    );
  end
  // masked-off lanes neither report illegal nor kill; lanes after the first illegal one are killed
  always_comb begin
    seen     = 1'b0;
    eff_mask = '0;
    wr_dec   = lane_dec;
    for (int i = 0; i < WIDTH; i++) begin
      wr_dec[i].illegal = lane_dec[i].illegal & lane_mask_i[i];
      eff_mask[i]       = lane_mask_i[i] & !seen;
      seen              = seen | wr_dec[i].illegal;
    end
  end
  assign ready_o      = count != CW'(DEPTH);
  assign valid_o      = count != '0;
  assign push         = valid_i && ready_o && |eff_mask && !flush_i;
  assign pop          = valid_o && ready_i && !flush_i;
  assign count_o      = count;
  assign dec_o        = valid_o ? mem_dec[rd_ptr] : '0;
  assign lane_valid_o = valid_o ? mem_mask[rd_ptr] : '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count  <= count + CW'(push) - CW'(pop);
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_dec[wr_ptr]  <= wr_dec;
      mem_mask[wr_ptr] <= eff_mask;
    end
  end
endmodule

// File: tb/tb_decode_bundle_queue.sv
// tb_decode_bundle_queue: directed vector table plus fill, flush and reset sequences
module tb_decode_bundle_queue;
  import decode_pkg::*;
  logic clk = 0, rst_ni = 0, flush_i = 0, valid_i = 0, ready_i = 0;
  logic ready_o, valid_o;
  logic [1:0] lane_mask_i = '0, lane_valid_o;
  logic [63:0] instr_i = '0;
  logic [31:0] pc_i = '0;
  decoded_t [1:0] dec_o;
  logic [2:0] count_o;
  int total = 0, passed = 0;
  decode_bundle_queue #(.WIDTH(2), .DEPTH(4), .XLEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .lane_mask_i(lane_mask_i), .instr_i(instr_i), .pc_i(pc_i), .valid_o(valid_o),
    .ready_i(ready_i), .lane_valid_o(lane_valid_o), .dec_o(dec_o), .count_o(count_o)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  typedef struct packed {
    logic [31:0] imm;
    logic [5:0]  rd;
    logic [5:0]  rs1;
    uop_e        uop;
    logic        we;
    logic        il;
    logic        civ;
    logic [11:0] csr;
  } lane_exp_t;
  typedef struct {
    logic [1:0]  mask;
    logic [31:0] i0, i1, pc;
    logic [1:0]  lv;
    lane_exp_t   l0, l1;
  } vec_t;
  function automatic lane_exp_t lx(logic [31:0] imm, logic [5:0] rd, logic [5:0] rs1, uop_e uop,
                                   logic we, logic il, logic civ, logic [11:0] csr);
    return '{imm, rd, rs1, uop, we, il, civ, csr};
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask
  lane_exp_t z;
  vec_t vecs[11];
  initial begin
    z = lx(0, 0, 0, UOP_ALU, 0, 0, 0, 0);
    vecs[0]  = '{2'b11, 32'h00500093, 32'h00A00113, 32'h1000, 2'b11,
                 lx(5, 1, 0, UOP_ALU, 1, 0, 0, 0), lx(10, 2, 0, UOP_ALU, 1, 0, 0, 0)};
    vecs[1]  = '{2'b11, 32'hFFFFFFFF, 32'h00000013, 32'h2000, 2'b01, lx(0, 0, 0, UOP_ALU, 0, 1, 0, 0), z};
    vecs[2]  = '{2'b10, 32'hFFFFFFFF, 32'h00000013, 32'h2000, 2'b10, z, z};
    vecs[3]  = '{2'b11, 32'h00112423, 32'hFE000EE3, 32'h3000, 2'b11,
                 lx(8, 8, 2, UOP_STORE, 0, 0, 0, 0), lx(32'hFFFFFFFC, 29, 0, UOP_BRANCH, 0, 0, 0, 0)};
    vecs[4]  = '{2'b11, 32'h3405D073, 32'h00000000, 32'h3100, 2'b11,
                 lx(11, 0, 0, UOP_CSR, 0, 0, 1, 12'h340), lx(0, 0, 0, UOP_ALU, 0, 1, 0, 0)};
    vecs[5]  = '{2'b00, 32'h00500093, 32'h00A00113, 32'h3200, 2'b00, z, z};
    vecs[6]  = '{2'b11, 32'h123450B7, 32'h008000EF, 32'h3300, 2'b11,
                 lx(32'h12345000, 1, 8, UOP_ALU, 1, 0, 0, 0), lx(8, 1, 0, UOP_JUMP, 1, 0, 0, 0)};
    vecs[7]  = '{2'b11, 32'hFFC12183, 32'h023100B3, 32'h3400, 2'b11,
                 lx(32'hFFFFFFFC, 3, 2, UOP_LOAD, 1, 0, 0, 0), lx(0, 0, 0, UOP_ALU, 0, 1, 0, 0)};
    vecs[8]  = '{2'b11, 32'h00001067, 32'h00500093, 32'h3500, 2'b01, lx(0, 0, 0, UOP_JUMP, 0, 1, 0, 0), z};
    vecs[9]  = '{2'b11, 32'h00000013, 32'h00004073, 32'h3600, 2'b11, z, lx(0, 0, 0, UOP_CSR, 0, 1, 0, 0)};
    vecs[10] = '{2'b10, 32'hFFFFFFFF, 32'h00500093, 32'h3700, 2'b10, z, lx(5, 1, 0, UOP_ALU, 1, 0, 0, 0)};
    #12;
    chk("rst.count", 64'(count_o), 0);
    chk("rst.valid", 64'(valid_o), 0);
    chk("rst.ready", 64'(ready_o), 1);
    chk("rst.lane_valid", 64'(lane_valid_o), 0);
    chk("rst.dec_zero", 64'(|dec_o), 0);
    @(negedge clk) rst_ni = 1;
    foreach (vecs[i]) begin
      @(negedge clk);
      valid_i = 1; ready_i = 0;
      lane_mask_i = vecs[i].mask;
      instr_i = {vecs[i].i1, vecs[i].i0};
      pc_i = vecs[i].pc;
      #1 chk($sformatf("v%0d.no_fallthru", i), 64'(valid_o), 0);
      @(negedge clk) valid_i = 0;
      chk($sformatf("v%0d.count", i), 64'(count_o), 64'(vecs[i].lv != 0));
      chk($sformatf("v%0d.valid", i), 64'(valid_o), 64'(vecs[i].lv != 0));
      chk($sformatf("v%0d.lane_valid", i), 64'(lane_valid_o), 64'(vecs[i].lv));
      for (int l = 0; l < 2; l++) begin
        lane_exp_t e;
        e = l ? vecs[i].l1 : vecs[i].l0;
        if (vecs[i].lv[l]) begin
          chk($sformatf("v%0d.l%0d.pc", i, l), 64'(dec_o[l].pc), 64'(vecs[i].pc + 32'(4*l)));
          chk($sformatf("v%0d.l%0d.illegal", i, l), 64'(dec_o[l].illegal), 64'(e.il));
          if (!e.il) begin
            chk($sformatf("v%0d.l%0d.imm", i, l), 64'(dec_o[l].imm), 64'(e.imm));
            chk($sformatf("v%0d.l%0d.rd", i, l), 64'(dec_o[l].rd), 64'(e.rd));
            chk($sformatf("v%0d.l%0d.rs1", i, l), 64'(dec_o[l].rs1), 64'(e.rs1));
            chk($sformatf("v%0d.l%0d.uop", i, l), 64'(dec_o[l].uop), 64'(e.uop));
            chk($sformatf("v%0d.l%0d.rd_we", i, l), 64'(dec_o[l].rd_we), 64'(e.we));
            chk($sformatf("v%0d.l%0d.csr_imm_valid", i, l), 64'(dec_o[l].csr_imm_valid), 64'(e.civ));
            if (e.uop == UOP_CSR) chk($sformatf("v%0d.l%0d.csr_addr", i, l), 64'(dec_o[l].csr_addr), 64'(e.csr));
          end
        end
      end
      ready_i = 1;
      @(negedge clk) ready_i = 0;
      chk($sformatf("v%0d.drained", i), 64'(count_o), 0);
    end
    // fill to full with rename stalled; the fifth bundle must be refused
    valid_i = 1; ready_i = 0; lane_mask_i = 2'b11; instr_i = {32'h00A00113, 32'h00500093};
    for (int n = 0; n < 5; n++) begin
      pc_i = 32'h4000 + 32'(16*n);
      @(negedge clk);
      if (n == 3) begin
        chk("fill.count4", 64'(count_o), 4);
        chk("fill.ready_low", 64'(ready_o), 0);
      end
    end
    chk("fill.count_after5", 64'(count_o), 4);
    chk("fill.head_pc", 64'(dec_o[0].pc), 32'h4000);
    chk("fill.head_l1_pc", 64'(dec_o[1].pc), 32'h4004);
    chk("fill.head_imm", 64'(dec_o[0].imm), 5);
    // pop while full refuses the push; afterwards push and pop balance
    pc_i = 32'h5000; ready_i = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stream%0d.count", c), 64'(count_o), 3);
      chk($sformatf("stream%0d.head_pc", c), 64'(dec_o[0].pc), 64'(32'h4010 + 32'(16*c)));
    end
    chk("stream.ready", 64'(ready_o), 1);
    // flush with push and pop both offered: everything discarded
    pc_i = 32'h6000; flush_i = 1;
    @(negedge clk);
    flush_i = 0; valid_i = 0; ready_i = 0;
    chk("flush.count", 64'(count_o), 0);
    chk("flush.valid", 64'(valid_o), 0);
    chk("flush.ready", 64'(ready_o), 1);
    @(negedge clk);
    chk("flush.no_incoming", 64'(valid_o), 0);
    chk("flush.no_incoming_count", 64'(count_o), 0);
    // asynchronous reset in the middle of a cycle
    valid_i = 1; pc_i = 32'h7000;
    @(negedge clk);
    @(negedge clk) valid_i = 0;
    chk("pre_rst.count", 64'(count_o), 2);
    #2 rst_ni = 0;
    #1;
    chk("arst.count", 64'(count_o), 0);
    chk("arst.valid", 64'(valid_o), 0);
    chk("arst.lane_valid", 64'(lane_valid_o), 0);
    chk("arst.dec_zero", 64'(|dec_o), 0);
    chk("arst.ready", 64'(ready_o), 1);
    @(negedge clk) rst_ni = 1;
    @(negedge clk);
    chk("post_rst.valid", 64'(valid_o), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
